// File: rtl/collision_pkg.sv
// collision_pkg: shared FSM states, contact flag bit positions and map helpers
// for the tile collision engine.
package collision_pkg;

    typedef enum logic [2:0] {
        IDLE, LOAD, H_PROBE, H_DRAIN, V_PROBE, V_DRAIN, COMMIT, DONE
    } state_t;

    localparam int RIGHT = 0;
    localparam int LEFT  = 1;
    localparam int DOWN  = 2;
    localparam int UP    = 3;

    // Only bit 0 of a tile id carries solidity; zero means a wall.
    function automatic logic is_solid(input logic [31:0] tile);
        return !tile[0];
    endfunction

    function automatic int tile_addr(input int row, input int col, input int cols);
        return row * cols + col;
    endfunction

endpackage

// File: rtl/tile_probe.sv
// tile_probe: walks one tile row or column span, one ROM address per cycle,
// tracks in-flight reads and accumulates a sticky solid hit.
module tile_probe
    import collision_pkg::*;
#(
    parameter int IDX_W    = 13,
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 5,
    parameter int MAP_COLS = 40,
    parameter int MAP_ROWS = 30,
    parameter int ROM_LAT  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    go,
    input  logic                    fix_row,
    input  logic signed [IDX_W-1:0] fixed,
    input  logic signed [IDX_W-1:0] first,
    input  logic signed [IDX_W-1:0] last,
    input  logic [DATA_W-1:0]       map_data,
    output logic [ADDR_W-1:0]       map_addr,
    output logic                    hit,
    output logic                    issuing,
    output logic                    probe_done
);

    logic signed [IDX_W-1:0] fix_q, cur, end_q, row, col;
    logic                    row_mode, in_map;
    // bit 0: address on the bus this cycle; bit ROM_LAT: its data is on map_data
    logic [ROM_LAT:0]        pend;

    always_comb begin
        row        = row_mode ? fix_q : cur;
        col        = row_mode ? cur : fix_q;
        in_map     = !row[IDX_W-1] && row < IDX_W'(MAP_ROWS) && !col[IDX_W-1] && col < IDX_W'(MAP_COLS);
        probe_done = !issuing && pend == '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issuing  <= 1'b0;
            row_mode <= 1'b0;
            fix_q    <= '0;
            cur      <= '0;
            end_q    <= '0;
            hit      <= 1'b0;
            pend     <= '0;
            map_addr <= '0;
        end else begin
            pend <= {pend[ROM_LAT-1:0], issuing && in_map};
            if (issuing && in_map)
                map_addr <= ADDR_W'(tile_addr(int'(row), int'(col), MAP_COLS));
            if (go) begin
                issuing  <= 1'b1;
                row_mode <= fix_row;
                fix_q    <= fixed;
                cur      <= first;
                end_q    <= last;
                hit      <= 1'b0;
            end else begin
                if (issuing) begin
                    cur     <= cur + IDX_W'(1);
                    issuing <= cur != end_q;
                end
                // off-map tiles are walls and never reach the ROM
                if ((issuing && !in_map) || (pend[ROM_LAT] && is_solid(32'(map_data))))
                    hit <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/tile_collision_engine.sv
// tile_collision_engine: per-frame resolver of object motion against the tile
// map, horizontal axis first, then vertical, for NUM_OBJ objects.
module tile_collision_engine
    import collision_pkg::*;
#(
    parameter int NUM_OBJ    = 2,
    parameter int POS_W      = 11,
    parameter int VEL_W      = 6,
    parameter int TILE_SHIFT = 4,
    parameter int OBJ_W      = 16,
    parameter int OBJ_H      = 16,
    parameter int MAP_COLS   = 40,
    parameter int MAP_ROWS   = 30,
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 5,
    parameter int ROM_LAT    = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [NUM_OBJ*POS_W-1:0] obj_x,
    input  logic [NUM_OBJ*POS_W-1:0] obj_y,
    input  logic [NUM_OBJ*VEL_W-1:0] obj_vx,
    input  logic [NUM_OBJ*VEL_W-1:0] obj_vy,
    output logic [ADDR_W-1:0]        map_addr,
    input  logic [DATA_W-1:0]        map_data,
    output logic                     busy,
    output logic                     done,
    output logic [NUM_OBJ*POS_W-1:0] x_out,
    output logic [NUM_OBJ*POS_W-1:0] y_out,
    output logic [NUM_OBJ*4-1:0]     flags
);

    localparam int SW = POS_W + 2;
    localparam int IW = NUM_OBJ > 1 ? $clog2(NUM_OBJ) : 1;

    state_t                   state, state_nx;
    logic [NUM_OBJ*POS_W-1:0] lx, ly, sx, sy;
    logic [NUM_OBJ*VEL_W-1:0] lvx, lvy;
    logic [NUM_OBJ*4-1:0]     sf;
    logic [IW-1:0]            idx;
    logic [1:0]               hflags;
    logic signed [SW-1:0]     cx, cy, vx, vy, xn, x_new, y_new, hcol, vrow, fixed, first, last;
    logic vx_pos, vx_neg, vy_pos, vy_neg, go_h, go_v, hit, issuing, probe_done, last_obj;

    always_comb begin
        cx     = SW'(lx[idx*POS_W +: POS_W]);
        cy     = SW'(ly[idx*POS_W +: POS_W]);
        vx     = SW'(signed'(lvx[idx*VEL_W +: VEL_W]));
        vy     = SW'(signed'(lvy[idx*VEL_W +: VEL_W]));
        vx_pos = !vx[SW-1] && vx != '0;
        vx_neg = vx[SW-1];
        vy_pos = !vy[SW-1] && vy != '0;
        vy_neg = vy[SW-1];
        hcol   = (vx_pos ? cx + SW'(OBJ_W - 1) + vx : cx + vx) >>> TILE_SHIFT;
        x_new  = !hit || !(vx_pos || vx_neg) ? cx + vx
               : vx_pos ? (hcol <<< TILE_SHIFT) - SW'(OBJ_W) : (hcol + SW'(1)) <<< TILE_SHIFT;
        // vy==0 still probes the row just below the feet for ground contact
        vrow   = (vy_pos ? cy + SW'(OBJ_H - 1) + vy : vy_neg ? cy + vy : cy + SW'(OBJ_H)) >>> TILE_SHIFT;
        y_new  = !hit || !(vy_pos || vy_neg) ? cy + vy
               : vy_pos ? (vrow <<< TILE_SHIFT) - SW'(OBJ_H) : (vrow + SW'(1)) <<< TILE_SHIFT;
        last_obj = idx == IW'(NUM_OBJ - 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? LOAD : IDLE;
            LOAD:    state_nx = go_h ? H_PROBE : V_PROBE;
            H_PROBE: state_nx = issuing ? H_PROBE : H_DRAIN;
            H_DRAIN: state_nx = probe_done ? V_PROBE : H_DRAIN;
            V_PROBE: state_nx = issuing ? V_PROBE : V_DRAIN;
            V_DRAIN: state_nx = probe_done ? COMMIT : V_DRAIN;
            COMMIT:  state_nx = last_obj ? DONE : LOAD;
            default: state_nx = IDLE;
        endcase
    end

    // the vertical span is launched from x_new in the same cycle it becomes final
    always_comb begin
        busy  = state != IDLE;
        go_h  = state == LOAD && (vx_pos || vx_neg);
        go_v  = (state == LOAD && !(vx_pos || vx_neg)) || (state == H_DRAIN && probe_done);
        fixed = go_v ? vrow : hcol;
        first = go_v ? x_new >>> TILE_SHIFT : cy >>> TILE_SHIFT;
        last  = go_v ? (x_new + SW'(OBJ_W - 1)) >>> TILE_SHIFT : (cy + SW'(OBJ_H - 1)) >>> TILE_SHIFT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lx     <= '0;
            ly     <= '0;
            lvx    <= '0;
            lvy    <= '0;
            sx     <= '0;
            sy     <= '0;
            sf     <= '0;
            idx    <= '0;
            xn     <= '0;
            hflags <= '0;
            done   <= 1'b0;
            x_out  <= '0;
            y_out  <= '0;
            flags  <= '0;
        end else begin
            if (state == IDLE && start) begin
                lx  <= obj_x;
                ly  <= obj_y;
                lvx <= obj_vx;
                lvy <= obj_vy;
                idx <= '0;
            end
            if (go_v) begin
                xn            <= x_new;
                hflags[RIGHT] <= vx_pos && hit;
                hflags[LEFT]  <= vx_neg && hit;
            end
            if (state == COMMIT) begin
                sx[idx*POS_W +: POS_W] <= xn[POS_W-1:0];
                sy[idx*POS_W +: POS_W] <= y_new[POS_W-1:0];
                sf[idx*4 + RIGHT]      <= hflags[RIGHT];
                sf[idx*4 + LEFT]       <= hflags[LEFT];
                sf[idx*4 + DOWN]       <= !vy_neg && hit;
                sf[idx*4 + UP]         <= vy_neg && hit;
                idx                    <= last_obj ? '0 : idx + 1'b1;
            end
            done <= state == DONE;
            if (state == DONE) begin
                x_out <= sx;
                y_out <= sy;
                flags <= sf;
            end
        end
    end

    tile_probe #(
        .IDX_W(SW), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .MAP_COLS(MAP_COLS), .MAP_ROWS(MAP_ROWS), .ROM_LAT(ROM_LAT)
    ) u_probe (
        .clk(clk), .rst_n(rst_n), .go(go_h || go_v), .fix_row(go_v),
        .fixed(fixed), .first(first), .last(last), .map_data(map_data),
        .map_addr(map_addr), .hit(hit), .issuing(issuing), .probe_done(probe_done)
    );

endmodule

// File: tb/tb_tile_collision_engine.sv
// tb_tile_collision_engine: vector table plus control sequences; expected
// results go to a scoreboard and are matched against each done pulse.
module tb_tile_collision_engine;

    localparam int PW = 11;
    localparam int VW = 6;
    localparam int MAX_LAT = 2 * (2 + 2 + 4 + 2 + 2) + 2;

    logic            clk = 0, rst_n, start = 0;
    logic [2*PW-1:0] obj_x = '0, obj_y = '0, x_out, y_out;
    logic [2*VW-1:0] obj_vx = '0, obj_vy = '0;
    logic [12:0]     map_addr;
    logic [4:0]      map_data;
    logic            busy, done;
    logic [7:0]      flags;

    typedef struct {
        int map;
        int x0, y0, vx0, vy0, x1, y1, vx1, vy1;
        int ex0, ey0, ef0, ex1, ey1, ef1;
    } vec_t;
    typedef struct { int x0, y0, f0, x1, y1, f1; } exp_t;

    exp_t sb[$];
    exp_t e;
    vec_t v [8];
    logic solid_map [1200];
    int   checks = 0, fails = 0, dones = 0, bad_reads = 0, d0;
    logic watch = 0;

    always #5 clk = ~clk;

    tile_collision_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .obj_x(obj_x), .obj_y(obj_y), .obj_vx(obj_vx), .obj_vy(obj_vy),
        .map_addr(map_addr), .map_data(map_data),
        .busy(busy), .done(done), .x_out(x_out), .y_out(y_out), .flags(flags)
    );

    // one-cycle ROM; upper data bits are noise that must not matter
    always_ff @(posedge clk)
        map_data <= {map_addr[3:0], !(map_addr >= 13'd1200 || solid_map[map_addr])};

    // addresses a wrapped column -1 read would produce for rows 6 and 7
    always @(posedge clk)
        if (watch && (map_addr == 13'd239 || map_addr == 13'd279)) bad_reads++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk)
        if (rst_n && done) begin
            dones++;
            if (sb.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                e = sb.pop_front();
                chk("x0", int'(x_out[PW-1:0]), e.x0);
                chk("y0", int'(y_out[PW-1:0]), e.y0);
                chk("flags0", int'(flags[3:0]), e.f0);
                chk("x1", int'(x_out[2*PW-1:PW]), e.x1);
                chk("y1", int'(y_out[2*PW-1:PW]), e.y1);
                chk("flags1", int'(flags[7:4]), e.f1);
            end
        end

    task automatic set_map(input int kind);
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 40; c++)
                solid_map[r*40 + c] = (kind == 1 && r == 10) || (kind == 2 && c == 20) || (kind == 3 && r == 5);
    endtask

    task automatic drive(input vec_t t);
        obj_x  = {PW'(t.x1), PW'(t.x0)};
        obj_y  = {PW'(t.y1), PW'(t.y0)};
        obj_vx = {VW'(t.vx1), VW'(t.vx0)};
        obj_vy = {VW'(t.vy1), VW'(t.vy0)};
    endtask

    task automatic push(input vec_t t);
        exp_t x;
        x = '{t.ex0, t.ey0, t.ef0, t.ex1, t.ey1, t.ef1};
        sb.push_back(x);
    endtask

    task automatic run_vec(input vec_t t);
        int lat;
        set_map(t.map);
        @(negedge clk);
        drive(t);
        push(t);
        start = 1;
        @(negedge clk);
        start = 0;
        obj_x = '1; obj_y = '1; obj_vx = '0; obj_vy = '0;
        lat = 1;
        while (!done && lat < MAX_LAT + 10) begin
            @(negedge clk);
            lat++;
        end
        chk("done_seen", int'(done), 1);
        chk("latency", lat, lat <= MAX_LAT ? lat : MAX_LAT);
        @(negedge clk);
        chk("done_one_cycle", int'(done), 0);
        chk("busy_after_done", int'(busy), 0);
    endtask

    initial begin
        v[0] = '{0, 100, 100,  0,  4, 200, 200, -3, -2, 100, 104, 0, 197, 198, 0};
        v[1] = '{1, 100, 142,  0,  4, 300,  50,  5,  0, 100, 144, 4, 305,  50, 0};
        v[2] = '{1, 100, 144,  0,  0,  50, 144,  2,  0, 100, 144, 4,  52, 144, 4};
        v[3] = '{2, 302, 100,  3,  0, 338,  60, -3,  0, 304, 100, 1, 336,  60, 2};
        v[4] = '{3, 100,  98,  0, -5, 200,  60,  0,  3, 100,  96, 8, 200,  63, 0};
        v[5] = '{0,   2, 100, -5,  0, 622, 100,  5,  0,   0, 100, 2, 624, 100, 1};
        v[6] = '{0,   0,   0,  0, -1, 100, 464,  0,  0,   0,   0, 8, 100, 464, 4};
        v[7] = '{1, 100, 140,  7,  7, 500, 300, -7, -7, 107, 144, 4, 493, 293, 0};
        set_map(0);
        rst_n = 1;
        #1 rst_n = 0;
        #5;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_map_addr", int'(map_addr), 0);
        chk("rst_x_out", int'(x_out), 0);
        chk("rst_y_out", int'(y_out), 0);
        chk("rst_flags", int'(flags), 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            watch = i == 5;
            run_vec(v[i]);
            watch = 0;
        end
        chk("no_read_col_minus1", bad_reads, 0);

        // a second start during a scan is dropped
        set_map(1);
        @(negedge clk);
        drive(v[1]);
        push(v[1]);
        d0 = dones;
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (3) @(negedge clk);
        chk("busy_mid_scan", int'(busy), 1);
        obj_x = {11'd400, 11'd400}; obj_vx = '0; obj_vy = '0;
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (60) @(negedge clk);
        chk("single_done", dones - d0, 1);
        chk("scoreboard_empty", sb.size(), 0);

        // asynchronous reset during a scan discards everything
        drive(v[7]);
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (5) @(negedge clk);
        rst_n = 0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_x_out", int'(x_out), 0);
        chk("abort_y_out", int'(y_out), 0);
        chk("abort_flags", int'(flags), 0);
        chk("abort_map_addr", int'(map_addr), 0);
        @(negedge clk);
        rst_n = 1;
        d0 = dones;
        repeat (40) @(negedge clk);
        chk("no_done_after_abort", dones - d0, 0);
        run_vec(v[3]);
        chk("final_scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/tile_collision_engine.md
Name: tile_collision_engine

Overview:
- Per-frame collision resolver for multiple game objects (player plus enemies) against the tile world map.
- Runs once per frame. It reads solidity from the shared world-map ROM, resolves signed velocities along the horizontal axis first and then the vertical axis, and returns clamped positions and contact flags.
- It sits between the per-object motion logic and the sprite renderer. It replaces the per-pixel scan with an address-driven tile probe that works in logical (scrolled) coordinates.

Parameters:
- NUM_OBJ, 2, number of objects resolved per start.
- POS_W, 11, width of logical pixel coordinates (unsigned).
- VEL_W, 6, width of signed two's-complement velocity; |v| must be less than 2**TILE_SHIFT.
- TILE_SHIFT, 4, log2 of tile edge in pixels (16 px tiles).
- OBJ_W, 16, object width in pixels.
- OBJ_H, 16, object height in pixels.
- MAP_COLS, 40, map width in tiles.
- MAP_ROWS, 30, map height in tiles.
- ADDR_W, 13, map ROM address width.
- DATA_W, 5, map ROM data width.
- ROM_LAT, 1, map ROM read latency in cycles (1..3).

Ports:
- Clk, in, 1, system clock.
- Reset_n, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle request to resolve all objects.
- obj_x, in, NUM_OBJ*POS_W, current logical X per object (top-left).
- obj_y, in, NUM_OBJ*POS_W, current Y per object.
- obj_vx, in, NUM_OBJ*VEL_W, signed X velocity per object.
- obj_vy, in, NUM_OBJ*VEL_W, signed Y velocity per object; positive means down.
- map_addr, out, ADDR_W, ROM address = row*MAP_COLS + col.
- map_data, in, DATA_W, tile id returned ROM_LAT cycles after the address.
- busy, out, 1, high from the cycle after start is accepted until done.
- done, out, 1, one-cycle pulse when all results are valid.
- x_out, out, NUM_OBJ*POS_W, resolved X per object.
- y_out, out, NUM_OBJ*POS_W, resolved Y per object.
- flags, out, NUM_OBJ*4, per object {up, down, left, right} contact.

Behaviour:
- Reset: busy=0, done=0, map_addr=0, x_out=0, y_out=0, flags=0, FSM=IDLE. Reset asserted mid-scan aborts the scan immediately; no partial results are written.
- Solid rule: a tile is solid when map_data[0]==0. A probe column <0 or >=MAP_COLS, or a probe row <0 or >=MAP_ROWS, counts as solid without issuing a ROM read.
- Handshake: start is sampled only in IDLE; start while busy is ignored. The inputs are latched into internal registers on acceptance, so they may change afterwards.
- FSM states: IDLE -> LOAD -> H_PROBE -> H_DRAIN -> V_PROBE -> V_DRAIN -> COMMIT. From COMMIT, go to LOAD for the next object, or to DONE after the last object. DONE -> IDLE.
- Arithmetic: use (POS_W+2)-bit signed arithmetic internally. Tile index = coordinate >>> TILE_SHIFT.
- Horizontal axis, vx>0:
  - Probe column of x+OBJ_W-1+vx over rows y>>S .. (y+OBJ_H-1)>>S.
  - Any hit gives x'=(col<<S)-OBJ_W and right=1; otherwise x'=x+vx.
- Horizontal axis, vx<0:
  - Probe column of x+vx over the same rows.
  - A hit gives x'=(col+1)<<S and left=1.
- Horizontal axis, vx==0: no probe; x'=x.
- Vertical axis uses x'. Columns probed are x'>>S .. (x'+OBJ_W-1)>>S.
  - vy>0: probe row of y+OBJ_H-1+vy. A hit gives y'=(row<<S)-OBJ_H and down=1.
  - vy<0: probe row of y+vy. A hit gives y'=(row+1)<<S and up=1.
  - vy==0 (ground check): probe row of y+OBJ_H. A hit sets down=1; y'=y.
- Probe timing:
  - One address is issued per cycle in *_PROBE.
  - A ROM_LAT-deep valid shift register tracks returning data; *_DRAIN waits until it is empty.
  - Hit = OR of the solid results over the span.
- Commit: COMMIT writes x_out/y_out/flags for the current object only. All outputs of all objects update in the same cycle that done pulses, via a shadow register, and hold until the next done.
- Latency: start to done is at most NUM_OBJ*(2*(OBJ_H>>S)+2*(OBJ_W>>S)+4+2*ROM_LAT+2)+2 cycles.

Decomposition:
- collision_pkg holds:
  - the FSM state enum;
  - flag bit indices (RIGHT=0, LEFT=1, DOWN=2, UP=3);
  - function is_solid(tile id);
  - function tile_addr(row, col).
- Sub-module tile_probe:
  - inputs: fixed-row or fixed-col mode, span start/end index, go;
  - outputs: map_addr, ROM_LAT valid tracking, sticky hit, probe_done;
  - it is instantiated once and shared by both axes.

Test Plan:
Bench setup: 16 px tiles, 16x16 object, ROM_LAT=1 model, empty map unless stated.
1. Free fall: obj0 (100,100), v=(0,+4) -> x=100, y=104, flags=0000. done pulses once and busy is low afterwards.
2. Landing: row 10 solid; obj0 (100,142), vy=+4 -> y_out=144, down=1. Repeat with vy=0 at y=144 -> y=144, down=1.
3. Right wall: column 20 solid; obj0 (302,100), vx=+3 -> x_out=304, right=1, y unchanged.
4. Ceiling: row 5 solid; obj0 (100,98), vy=-5 -> y_out=96, up=1.
5. Map edge: obj0 (2,100), vx=-5 -> x_out=0, left=1, with no ROM read for column -1. Also obj0 (622,100), vx=+5 -> x_out=624, right=1.
6. Control:
   - NUM_OBJ=2 with distinct results: both objects correct and updated in the same done cycle.
   - start pulsed while busy: ignored.
   - Reset_n low mid-scan: busy=0, outputs=0.
   - Done latency at or below the stated bound.
